alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage consumer of the operand-select outputs DATA0, DATA1 and ALU_EN. It also takes OPCODE, FUNCT3 and instruction bit 30 from decode.
- Computes the RV32I integer result with a valid/ready handshake on both input and output.
- Add, compare and logic ops take one cycle. Shifts are iterative, one bit per cycle, to save area.
- Feeds writeback and the load/store address path.

Parameters:
- XLEN, 32, datapath width.
- ITERATIVE_SHIFT, 1, 1 = shift one bit per cycle; 0 = barrel shift in one cycle, same latency as add.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- ALU_EN  in  1  input valid; operands and controls are valid this cycle.
- IN_READY  out  1  unit can accept a new operation.
- DATA0  in  XLEN  operand A.
- DATA1  in  XLEN  operand B; bits [4:0] are the shift amount.
- OPCODE  in  7  instruction opcode.
- FUNCT3  in  3  instruction funct3.
- FUNCT7_5  in  1  instruction bit 30; selects SUB or SRA/SRAI.
- RESULT  out  XLEN  registered result.
- OUT_VALID  out  1  RESULT is valid.
- OUT_READY  in  1  downstream accepts RESULT.
- BUSY  out  1  an iterative shift is in progress.

Behaviour:
- Reset (async, any state): state = IDLE; RESULT = 0; OUT_VALID = 0; BUSY = 0; IN_READY = 1 after release; shift counter = 0.
- Op decode (combinational, from OPCODE, FUNCT3, FUNCT7_5):
  - OPCODE 0000011, 0100011, 0110111, 0010111: always ADD (address / LUI / AUIPC).
  - OPCODE 0110011: funct3 000 gives SUB if FUNCT7_5 = 1, else ADD.
  - OPCODE 0010011: funct3 000 is always ADD; FUNCT7_5 is ignored.
  - Both 0010011 and 0110011, remaining funct3 values:
    - 001 SLL.
    - 010 SLT (signed).
    - 011 SLTU.
    - 100 XOR.
    - 101 SRA if FUNCT7_5 = 1, else SRL.
    - 110 OR.
    - 111 AND.
  - Any other OPCODE: ADD.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce a 0/1 result, zero-extended.
  - Shift amount is DATA1[4:0]; DATA1[31:5] is ignored.
  - SRA replicates DATA0[31] at every step.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY = 1.
  - On ALU_EN, for a non-shift op (or any op with ITERATIVE_SHIFT = 0): register the result, go to DONE.
  - On ALU_EN, for a shift with shamt = 0: RESULT = DATA0, go to DONE.
  - On ALU_EN, for a shift with shamt > 0: load shift register = DATA0 and counter = shamt, latch direction/arith, go to SHIFT.
- SHIFT:
  - BUSY = 1, IN_READY = 0.
  - Each cycle: shift one bit, decrement the counter.
  - When the counter reaches 0: RESULT = shift register, go to DONE.
- DONE:
  - OUT_VALID = 1; RESULT is held stable; IN_READY = 0.
  - On OUT_READY: OUT_VALID falls next cycle, go to IDLE.
  - No same-cycle accept of a new op; throughput is at most one op per 2 cycles.
- Latency, with acceptance in cycle N:
  - OUT_VALID in cycle N+1 for non-shift ops or shamt = 0.
  - OUT_VALID in cycle N+1+shamt for iterative shifts (shamt = 31 gives N+32).
- Boundary conditions:
  - ALU_EN while IN_READY = 0: ignored; upstream must hold its operands.
  - OUT_READY outside DONE: ignored.
  - OUT_READY held low: DONE persists indefinitely, RESULT unchanged.
  - RESET mid-SHIFT or in DONE: operation is discarded and the result is never presented.
  - Operands changing during SHIFT: no effect, because they are latched.

Decomposition:
- Package alu_exec_pkg contains:
  - opcode constants (OP_IMM, OP_REG, LOAD, STORE, LUI, AUIPC);
  - funct3 constants;
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - state_e enum (IDLE, SHIFT, DONE).
- Sub-module alu_op_decode: combinational mapping of OPCODE/FUNCT3/FUNCT7_5 to alu_op_e. It is shared with the future forwarding/hazard logic.

Test Plan:
- R-type SUB: OPCODE 0110011, FUNCT3 000, FUNCT7_5 1, DATA0 5, DATA1 7 -> RESULT 32'hFFFFFFFE, OUT_VALID at N+1.
- ADDI with bit30 set: OPCODE 0010011, FUNCT3 000, FUNCT7_5 1, DATA0 10, DATA1 32'hFFFFFFFF -> RESULT 9 (add, not sub).
- SRAI: OPCODE 0010011, FUNCT3 101, FUNCT7_5 1, DATA0 32'h80000000, DATA1 31 -> RESULT 32'hFFFFFFFF.
  - BUSY is high for 31 cycles; OUT_VALID at N+32.
  - SLL with shamt 0 and DATA0 32'h1234 -> 32'h1234 at N+1.
- SLT vs SLTU with DATA0 32'hFFFFFFFF, DATA1 1 -> SLT gives 1, SLTU gives 0.
- Backpressure: complete an op with OUT_READY low for 5 cycles -> OUT_VALID and RESULT stable, IN_READY 0.
  - With a second ALU_EN pulse in that window: the pulse is ignored.
  - On OUT_READY high: IDLE next cycle.
- Reset mid-shift: SLL with shamt 20, assert RESET at shift cycle 8 -> RESULT 0, OUT_VALID 0, BUSY 0 immediately.
  - After release, ADD 3+4 gives 7 at N+1.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU.
// Provides the opcode and funct3 constants, the decoded ALU operation enum
// and the ALU FSM state encoding.
package alu_exec_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_unit_decode.sv
// alu_op_decode: maps OPCODE/FUNCT3/bit30 to the ALU operation.
// Purely combinational so the hazard/forwarding logic can reuse it.
// Ports: i_opcode, i_funct3, i_funct7_5 in; o_op out (alu_op_e).
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output alu_op_e    o_op
);

  always_comb begin
    o_op = ALU_ADD;
    case (i_opcode)
      OP_REG, OP_IMM: begin
        case (i_funct3)
          // Bit 30 means SUB only for register-register; ADDI ignores it.
          F3_ADD_SUB: o_op = (i_opcode == OP_REG && i_funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLL:     o_op = ALU_SLL;
          F3_SLT:     o_op = ALU_SLT;
          F3_SLTU:    o_op = ALU_SLTU;
          F3_XOR:     o_op = ALU_XOR;
          F3_SR:      o_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
          F3_OR:      o_op = ALU_OR;
          F3_AND:     o_op = ALU_AND;
          default:    o_op = ALU_ADD;
        endcase
      end
      LOAD, STORE, LUI, AUIPC: o_op = ALU_ADD;
      default:                 o_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage integer ALU with valid/ready handshake on both sides.
// Single-cycle add/compare/logic; shifts iterate one bit per cycle unless
// ITERATIVE_SHIFT = 0, in which case they use a barrel shifter.
// Ports: CLK, RESET (async, active-high); ALU_EN/IN_READY input handshake;
// DATA0/DATA1 operands; OPCODE/FUNCT3/FUNCT7_5 controls; RESULT/OUT_VALID/
// OUT_READY output handshake; BUSY while an iterative shift runs.
//
// state | meaning
// IDLE  | ready for a new operation
// SHIFT | iterative shift running, one bit per cycle
// DONE  | RESULT presented, waiting for OUT_READY
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit ITERATIVE_SHIFT = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ALU_EN,
  output logic            IN_READY,
  input  logic [XLEN-1:0] DATA0,
  input  logic [XLEN-1:0] DATA1,
  input  logic [6:0]      OPCODE,
  input  logic [2:0]      FUNCT3,
  input  logic            FUNCT7_5,
  output logic [XLEN-1:0] RESULT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            BUSY
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]             r_state;
  logic [XLEN-1:0]        r_result;
  logic [XLEN-1:0]        r_shreg;
  logic [SHW-1:0]         r_cnt;
  logic                   r_left;
  logic                   r_arith;

  alu_op_e                w_op;
  logic [SHW-1:0]         w_shamt;
  logic                   w_is_shift;
  logic                   w_start_iter;
  logic signed [XLEN-1:0] w_data0_s;
  logic [XLEN-1:0]        w_comb_result;
  logic [XLEN-1:0]        w_shreg_next;

  alu_op_decode u_decode (
    .i_opcode   (OPCODE),
    .i_funct3   (FUNCT3),
    .i_funct7_5 (FUNCT7_5),
    .o_op       (w_op)
  );

  assign w_shamt      = DATA1[SHW-1:0];
  assign w_data0_s    = DATA0;
  assign w_is_shift   = (w_op == ALU_SLL) || (w_op == ALU_SRL) || (w_op == ALU_SRA);
  // A zero shift amount skips SHIFT; the combinational path already yields DATA0.
  assign w_start_iter = ITERATIVE_SHIFT && w_is_shift && (w_shamt != '0);

  always_comb begin
    w_comb_result = '0;
    case (w_op)
      ALU_ADD:  w_comb_result = DATA0 + DATA1;
      ALU_SUB:  w_comb_result = DATA0 - DATA1;
      ALU_SLL:  w_comb_result = DATA0 << w_shamt;
      ALU_SLT:  w_comb_result = {{(XLEN-1){1'b0}}, ($signed(DATA0) < $signed(DATA1))};
      ALU_SLTU: w_comb_result = {{(XLEN-1){1'b0}}, (DATA0 < DATA1)};
      ALU_XOR:  w_comb_result = DATA0 ^ DATA1;
      ALU_SRL:  w_comb_result = DATA0 >> w_shamt;
      ALU_SRA:  w_comb_result = w_data0_s >>> w_shamt;
      ALU_OR:   w_comb_result = DATA0 | DATA1;
      ALU_AND:  w_comb_result = DATA0 & DATA1;
      default:  w_comb_result = '0;
    endcase
  end

  // The MSB stays in place during an arithmetic right shift, so the original
  // sign bit is replicated at every step.
  assign w_shreg_next = r_left ? {r_shreg[XLEN-2:0], 1'b0}
                               : {r_arith & r_shreg[XLEN-1], r_shreg[XLEN-1:1]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ALU_EN) begin
            if (w_start_iter) begin
              r_shreg <= DATA0;
              r_cnt   <= w_shamt;
              r_left  <= (w_op == ALU_SLL);
              r_arith <= (w_op == ALU_SRA);
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_comb_result;
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_shreg <= w_shreg_next;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_result <= w_shreg_next;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (OUT_READY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IN_READY  = (r_state == S_IDLE);
  assign BUSY      = (r_state == S_SHIFT);
  assign OUT_VALID = (r_state == S_DONE);
  assign RESULT    = r_result;

endmodule
